// File: rtl/pipo_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipo_reg
// Purpose  : Parallel-in, parallel-out storage register. Built as a row of
//            identical D flip-flop cells, each with true and complemented
//            outputs, sharing one clock and one synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module pipo_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // One independent flip-flop cell per data bit.
  // qbar is derived from the stored bit, never from din, so q and qbar
  // can never disagree.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic r_q;

      // Capture this bit's data each rising edge; reset forces its RST_VAL bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= RST_VAL[gi];
        end else begin
          r_q <= din[gi];
        end
      end

      assign q[gi]    = r_q;
      assign qbar[gi] = ~r_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipo_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipo_reg
// Purpose  : Directed self-checking bench for pipo_reg (default 4-bit build
//            and an 8-bit build with a non-zero reset value).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipo_reg;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [3:0] q;
  logic [3:0] qbar;

  logic       rst8;
  logic [7:0] din8;
  logic [7:0] q8;
  logic [7:0] qbar8;

  int n_total;
  int n_pass;
  int n_fail;

  pipo_reg u_dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .q    (q),
    .qbar (qbar)
  );

  pipo_reg #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dut8 (
    .clk  (clk),
    .rst  (rst8),
    .din  (din8),
    .q    (q8),
    .qbar (qbar8)
  );

  // 20 ns period, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge.
  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] v;

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst  = 1'b1;
    din  = 4'bxxxx;
    rst8 = 1'b0;
    din8 = 8'h00;

    // Reset over the 10 ns edge
    after_rise();
    chk("reset_q",    {4'h0, q},    8'h00);
    chk("reset_qbar", {4'h0, qbar}, 8'h0F);

    // Release at 15 ns with din=0000; 30 ns edge loads it
    #4;
    rst = 1'b0;
    din = 4'b0000;
    after_rise();
    chk("release_q",    {4'h0, q},    8'h00);
    chk("release_qbar", {4'h0, qbar}, 8'h0F);

    // Load 1010 at the 50 ns edge
    @(negedge clk);
    din = 4'b1010;
    after_rise();
    chk("load_q",    {4'h0, q},    8'h0A);
    chk("load_qbar", {4'h0, qbar}, 8'h05);

    // Hold between edges
    @(negedge clk);
    din = 4'b0011;
    after_rise();
    chk("hold_pre_q", {4'h0, q}, 8'h03);
    @(negedge clk);
    din = 4'b1100;
    #1;
    chk("hold_mid_q", {4'h0, q}, 8'h03);
    // rst asserted between edges must not act until the edge
    rst = 1'b1;
    #1;
    chk("rst_between_edges_q", {4'h0, q}, 8'h03);
    rst = 1'b0;
    after_rise();
    chk("hold_post_q",    {4'h0, q},    8'h0C);
    chk("hold_post_qbar", {4'h0, qbar}, 8'h03);

    // Random stream, with forced all-ones / all-zeros words
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 5)       v = 4'b1111;
      else if (i == 10) v = 4'b0000;
      else              v = 4'($urandom);
      din = v;
      after_rise();
      chk("stream_q",    {4'h0, q},    {4'h0, v});
      chk("stream_qbar", {4'h0, qbar}, {4'h0, ~v});
    end

    // Reset mid-stream
    @(negedge clk);
    din = 4'b1111;
    after_rise();
    chk("pre_midrst_q", {4'h0, q}, 8'h0F);
    @(negedge clk);
    rst = 1'b1;
    din = 4'b0110;
    after_rise();
    chk("midrst_q",    {4'h0, q},    8'h00);
    chk("midrst_qbar", {4'h0, qbar}, 8'h0F);
    @(negedge clk);
    rst = 1'b0;
    after_rise();
    chk("post_midrst_q",    {4'h0, q},    8'h06);
    chk("post_midrst_qbar", {4'h0, qbar}, 8'h09);
    @(negedge clk);
    din = 4'b1001;
    after_rise();
    chk("resume_q", {4'h0, q}, 8'h09);

    // Parameter variant: WIDTH=8, RST_VAL=A5
    @(negedge clk);
    rst8 = 1'b1;
    din8 = 8'h3C;
    after_rise();
    chk("w8_reset_q",    q8,    8'hA5);
    chk("w8_reset_qbar", qbar8, 8'h5A);
    @(negedge clk);
    rst8 = 1'b0;
    after_rise();
    chk("w8_load_q",    q8,    8'h3C);
    chk("w8_load_qbar", qbar8, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipo_reg.md
# pipo_reg

Parallel-in, parallel-out (PIPO) storage register. Captures the full `din` word on every rising clock edge and presents it on `q`, with its bitwise complement on `qbar`. It is a general-purpose pipeline/holding stage. It is built as a row of identical D flip-flop cells, each with true and complemented outputs, sharing one clock and one reset.

## Interface
- `WIDTH`, default 4, number of data bits (≥1).
- `RST_VAL`, default 0, `WIDTH`-bit value loaded into `q` on reset.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `din`  input  WIDTH  parallel data in.
- `q`  output  WIDTH  registered data out.
- `qbar`  output  WIDTH  bitwise complement of `q`.

## Operation
- No load enable: the register loads unconditionally every rising edge while `rst`=0.
- Rising edge with `rst`=1: `q` ← `RST_VAL`, `qbar` ← `~RST_VAL`. Reset overrides `din`.
- Rising edge with `rst`=0: `q` ← `din`, `qbar` ← `~din`.
- Between edges, `q`/`qbar` hold; `din` changes have no effect.
- Invariant: `qbar == ~q` at all times after the first clock edge. There is no cycle where they disagree.
  - Each bit is its own flip-flop cell with complementary outputs.
  - `qbar` is not separately registered from `din`.
- Bits are independent: bit i of `q` depends only on bit i of `din` and the shared `rst`.
- Before the first rising edge after power-up, `q`/`qbar` are undefined (X in simulation). No asynchronous initialisation.
- `din` containing X/Z is captured as-is. No sanitisation.

## Timing
- Latency: 1 clock. `din` sampled at edge N appears on `q` immediately after edge N (clock-to-q only).
- Reset:
  - Takes effect at the first rising edge where `rst`=1.
  - Asserting or deasserting `rst` between edges has no effect until the next edge.
- Reset release: the first edge with `rst`=0 loads `din`. There is no dead cycle after reset.
- Reset mid-operation: the edge with `rst`=1 discards that edge's `din` and forces `RST_VAL`. The data stream resumes on the following edge.
- No combinational path from `din` or `rst` to the outputs.
- `din` must meet setup/hold around the rising edge. Stimulus should change `din` away from rising edges (e.g., on falling edges).

## Test plan
- Reset:
  - Stimulus: `clk` period 20 ns, `rst`=1 over the edge at 10 ns, `din`=X.
  - Required: `q`=0000, `qbar`=1111 after the 10 ns edge.
- Release and load:
  - Stimulus: `rst`=0 at 15 ns, `din`=0000.
  - Required: edge at 30 ns gives `q`=0000, `qbar`=1111.
  - Stimulus: `din`=1010 applied before the 50 ns edge.
  - Required: `q`=1010, `qbar`=0101 after that edge.
- Hold between edges:
  - Stimulus: change `din` 0011→1100 on a falling edge.
  - Required: `q` stays 0011 until the next rising edge, then becomes 1100, `qbar`=0011.
- Random stream:
  - Stimulus: ~25 edges of `$random` `din`, changing only on falling edges.
  - Required every cycle:
    - `q` equals the `din` at the previous rising edge.
    - `qbar == ~q`.
    - All-ones and all-zeros words appear correctly.
- Reset mid-stream:
  - Stimulus: with `q`=1111, assert `rst` over one edge while `din`=0110.
  - Required: `q`=0000 (`RST_VAL`), not 0110.
  - Stimulus: deassert `rst`.
  - Required: next edge loads the current `din`.
- Parameter variant:
  - Stimulus: `WIDTH`=8, `RST_VAL`=8'hA5; reset, then `din`=8'h3C.
  - Required: after reset `q`=A5, `qbar`=5A; next edge `q`=3C, `qbar`=C3.
